instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Instruction-fetch stage sitting directly upstream of the datapath. It owns the program counter and runs a req/ack handshake with instruction memory. Fetched words are held in an instruction register that drives the datapath's instruction input. It also supports datapath stall, branch redirect and a prefetch-abort timeout.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset.
PC_STEP, 4, byte increment per sequential fetch.
TIMEOUT, 15, maximum FETCH cycles without MemAck before abort (1..255).
NOP_WORD, 32'hE1A00000, Instruction value on reset and after flush (MOV R0,R0).

Ports:
Clk  in  1  system clock, rising edge.
Clr  in  1  reset, asynchronous, active-high.
MemReq  out  1  fetch request to instruction memory.
MemAddr  out  32  fetch address; equals PC while MemReq=1.
MemAck  in  1  memory has placed valid word on MemData this cycle.
MemData  in  32  fetched instruction word.
Stall  in  1  datapath cannot accept a new instruction.
BranchTaken  in  1  redirect request from datapath.
BranchTarget  in  32  redirect address.
Instruction  out  32  instruction register to datapath.
InstrValid  out  1  Instruction holds a fetched, unconsumed word.
InstrPC  out  32  address of the word in Instruction, or the faulting PC in ABORT.
FetchAbort  out  1  fetch timed out; sticky until redirect or reset.

Behaviour:
- Reset (Clr=1, async): PC=RESET_PC, state=IDLE, MemReq=0, MemAddr=RESET_PC, Instruction=NOP_WORD, InstrValid=0, InstrPC=RESET_PC, FetchAbort=0, wait counter=0.
- All outputs are registered or decoded from state only. No combinational path from inputs to outputs.
- MemAddr always equals PC.
- IDLE: MemReq=0. Next cycle goes to FETCH unconditionally. Entered after reset and for one cycle after every redirect.
- FETCH: MemReq=1, MemAddr stable. The wait counter increments each cycle without MemAck.
  - On MemAck: Instruction<=MemData, InstrPC<=PC, PC<=PC+PC_STEP, counter<=0, go to FULL.
  - When the counter reaches TIMEOUT with no ack: go to ABORT.
- FULL: InstrValid=1, MemReq=0.
  - Stall=1: hold all state; Instruction is stable.
  - Stall=0: the word is consumed at this edge. Go to FETCH; InstrValid=0 in the next cycle.
  - Minimum cadence is one instruction per 2 cycles (zero-wait memory).
- ABORT: FetchAbort=1, MemReq=0, InstrValid=0, InstrPC=faulting PC. Stays here until BranchTaken or Clr.
- BranchTaken=1 in any state has highest priority over MemAck, timeout and Stall:
  - PC<=BranchTarget with bits[1:0] forced to 0.
  - InstrValid<=0, Instruction<=NOP_WORD, FetchAbort<=0, counter<=0, go to IDLE.
  - A MemAck in the same cycle is discarded.
- MemReq drops for at least one cycle between an abandoned request and the redirected request.
- PC arithmetic is modulo 2^32: 32'hFFFFFFFC + 4 = 32'h00000000. No flag is raised on wrap.
- MemAck outside FETCH is ignored.
- Clr asserted mid-fetch drops MemReq immediately (async). The pending word is lost.

Decomposition:
- Shared package (arm_pkg): fetch state enum {IDLE, FETCH, FULL, ABORT}, NOP_WORD constant, PC width constant 32.
- One natural sub-module, fetch_pc_reg: PC register with async Clr, load (redirect), increment, and alignment masking.
- FSM, wait counter and instruction register stay in instr_fetch_unit.

Test Plan:
1. Clr=1 for 5 cycles -> MemReq=0, InstrValid=0, Instruction=E1A00000, MemAddr=0. Release Clr -> one IDLE cycle, then MemReq=1, MemAddr=0x0.
2. Zero-wait memory returns 03B01001, 03B0A003, 02912003 with Stall=0 -> Instruction shows them in order with InstrPC 0x0/0x4/0x8. MemAddr sequence is 0x0/0x4/0x8/0xC. InstrValid pulses every 2nd cycle.
3. Stall=1 for 3 cycles while FULL with 00923001 -> Instruction and InstrValid=1 held, MemReq=0. Stall=0 -> next fetch at PC+4.
4. MemAck withheld, BranchTaken=1 with target 0x103 -> MemReq=0 next cycle, then MemAddr=0x100. A late MemAck with DEADBEEF in the redirect cycle never appears on Instruction.
5. No MemAck with TIMEOUT=15 -> FetchAbort=1 after 15 FETCH cycles, InstrPC=faulting PC. BranchTaken to 0x0C clears FetchAbort and fetches at 0x0C. Clr asserted during ABORT also clears it.
6. RESET_PC=32'hFFFFFFFC, one acked fetch -> InstrPC=FFFFFFFC, next MemAddr=0x00000000.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared definitions for the instruction-fetch slice.
// Contents: fetch FSM state type, PC width, default NOP instruction word.
package arm_pkg;

    localparam int PC_W = 32;

    // MOV R0,R0: harmless filler presented to the datapath when no real word is held
    localparam logic [31:0] NOP_WORD = 32'hE1A00000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2,
        ABORT = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register.
// Ports:
//   Clk    - system clock, rising edge
//   Clr    - asynchronous active-high reset, loads RESET_PC
//   load   - redirect: take target with the low two bits cleared (wins over inc)
//   target - redirect address
//   inc    - advance by PC_STEP (wraps modulo 2^32, no flag)
//   pc     - current program counter
module fetch_pc_reg
    import arm_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'h00000000,
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic            Clk,
    input  logic            Clr,
    input  logic            load,
    input  logic [PC_W-1:0] target,
    input  logic            inc,
    output logic [PC_W-1:0] pc
);

    localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= {target[PC_W-1:2], 2'b00};
        end else if (inc) begin
            pc <= pc + STEP;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the req/ack handshake with
// instruction memory and holds the fetched word for the datapath.
// Ports:
//   Clk, Clr      - clock (rising edge), async active-high reset
//   MemReq        - fetch request (high only in FETCH)
//   MemAddr       - fetch address, always the PC
//   MemAck        - memory word valid on MemData this cycle
//   MemData       - fetched word
//   Stall         - datapath cannot take the held word
//   BranchTaken   - redirect, highest priority in every state
//   BranchTarget  - redirect address (low two bits ignored)
//   Instruction   - instruction register
//   InstrValid    - Instruction holds an unconsumed fetched word
//   InstrPC       - address of Instruction, or faulting PC after abort
//   FetchAbort    - fetch timed out, sticky until redirect or reset
//
// state | meaning
// IDLE  | one quiet cycle after reset or redirect, MemReq low
// FETCH | request outstanding, counting unacked cycles
// FULL  | word held for the datapath, waiting for Stall=0
// ABORT | memory never answered, parked until redirect or reset
module instr_fetch_unit
    import arm_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'h00000000,
    parameter int unsigned     PC_STEP  = 4,
    parameter int unsigned     TIMEOUT  = 15,
    parameter logic [31:0]     NOP_WORD = arm_pkg::NOP_WORD
) (
    input  logic            Clk,
    input  logic            Clr,
    output logic            MemReq,
    output logic [PC_W-1:0] MemAddr,
    input  logic            MemAck,
    input  logic [31:0]     MemData,
    input  logic            Stall,
    input  logic            BranchTaken,
    input  logic [PC_W-1:0] BranchTarget,
    output logic [31:0]     Instruction,
    output logic            InstrValid,
    output logic [PC_W-1:0] InstrPC,
    output logic            FetchAbort
);

    // Counter holds the number of unacked FETCH cycles already elapsed, so the
    // cycle that would make it TIMEOUT is the one that aborts.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    fetch_state_t    state_q;
    fetch_state_t    state_d;
    logic [7:0]      cnt_q;
    logic [PC_W-1:0] pc;
    logic            timeout_hit;
    logic            ack_taken;

    assign timeout_hit = (cnt_q == CNT_LAST);
    assign ack_taken   = (state_q == FETCH) && MemAck && !BranchTaken;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc (
        .Clk    (Clk),
        .Clr    (Clr),
        .load   (BranchTaken),
        .target (BranchTarget),
        .inc    (ack_taken),
        .pc     (pc)
    );

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (BranchTaken) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = FETCH;
                FETCH: begin
                    if (MemAck) begin
                        state_d = FULL;
                    end else if (timeout_hit) begin
                        state_d = ABORT;
                    end
                end
                FULL: begin
                    if (!Stall) begin
                        state_d = FETCH;
                    end
                end
                ABORT:   state_d = ABORT;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        MemReq     = (state_q == FETCH);
        InstrValid = (state_q == FULL);
        FetchAbort = (state_q == ABORT);
    end

    assign MemAddr = pc;

    // Instruction register, InstrPC and wait counter. A redirect discards any
    // same-cycle MemAck, so it is tested first.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            Instruction <= NOP_WORD;
            InstrPC     <= RESET_PC;
            cnt_q       <= 8'd0;
        end else if (BranchTaken) begin
            Instruction <= NOP_WORD;
            cnt_q       <= 8'd0;
        end else if (state_q == FETCH) begin
            if (MemAck) begin
                Instruction <= MemData;
                InstrPC     <= pc;
                cnt_q       <= 8'd0;
            end else if (timeout_hit) begin
                InstrPC     <= pc;
            end else begin
                cnt_q       <= cnt_q + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios followed by
// randomized traffic, all checked against a transaction-level model.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP     = 32'hE1A00000;
    localparam int          TIMEOUT = 15;

    logic        Clk = 1'b0;
    logic        Clr = 1'b1;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic        MemAck = 1'b0;
    logic [31:0] MemData = '0;
    logic        Stall = 1'b0;
    logic        BranchTaken = 1'b0;
    logic [31:0] BranchTarget = '0;
    logic [31:0] Instruction;
    logic        InstrValid;
    logic [31:0] InstrPC;
    logic        FetchAbort;

    // wrap-around instance: zero-wait memory, never stalled or redirected
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_ack = 1'b1;
    logic [31:0] w_data = 32'h11223344;
    logic        w_stall = 1'b0;
    logic        w_branch = 1'b0;
    logic [31:0] w_target = '0;
    logic [31:0] w_instr;
    logic        w_valid;
    logic [31:0] w_ipc;
    logic        w_abort;

    int vectors = 0;
    int miscompares = 0;

    always #5 Clk = ~Clk;

    instr_fetch_unit #(.TIMEOUT(TIMEOUT)) dut (
        .Clk          (Clk),
        .Clr          (Clr),
        .MemReq       (MemReq),
        .MemAddr      (MemAddr),
        .MemAck       (MemAck),
        .MemData      (MemData),
        .Stall        (Stall),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .Instruction  (Instruction),
        .InstrValid   (InstrValid),
        .InstrPC      (InstrPC),
        .FetchAbort   (FetchAbort)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFFFFFC)) dut_w (
        .Clk          (Clk),
        .Clr          (Clr),
        .MemReq       (w_req),
        .MemAddr      (w_addr),
        .MemAck       (w_ack),
        .MemData      (w_data),
        .Stall        (w_stall),
        .BranchTaken  (w_branch),
        .BranchTarget (w_target),
        .Instruction  (w_instr),
        .InstrValid   (w_valid),
        .InstrPC      (w_ipc),
        .FetchAbort   (w_abort)
    );

    // Reference model: what the fetch stage is doing, in transaction terms
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    bit          m_req;      // request outstanding
    bit          m_valid;    // holding an unconsumed word
    bit          m_abort;    // gave up waiting for memory
    int          m_waits;    // unanswered request cycles so far

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_instr = NOP;
        m_ipc   = 32'h0;
        m_req   = 0;
        m_valid = 0;
        m_abort = 0;
        m_waits = 0;
    endtask

    task automatic model_step();
        if (Clr) begin
            model_reset();
        end else if (BranchTaken) begin
            m_pc    = BranchTarget & ~32'h3;
            m_instr = NOP;
            m_valid = 0;
            m_abort = 0;
            m_req   = 0;
            m_waits = 0;
        end else if (m_req) begin
            if (MemAck) begin
                m_instr = MemData;
                m_ipc   = m_pc;
                m_pc    = m_pc + 32'd4;
                m_req   = 0;
                m_valid = 1;
                m_waits = 0;
            end else begin
                m_waits++;
                if (m_waits == TIMEOUT) begin
                    m_req   = 0;
                    m_abort = 1;
                    m_ipc   = m_pc;
                end
            end
        end else if (m_valid) begin
            if (!Stall) begin
                m_valid = 0;
                m_req   = 1;
            end
        end else if (!m_abort) begin
            m_req = 1;   // the quiet cycle after reset/redirect is over
        end
    endtask

    task automatic check_all();
        chk("MemReq",      MemReq,      m_req);
        chk("MemAddr",     MemAddr,     m_pc);
        chk("Instruction", Instruction, m_instr);
        chk("InstrValid",  InstrValid,  m_valid);
        chk("InstrPC",     InstrPC,     m_ipc);
        chk("FetchAbort",  FetchAbort,  m_abort);
    endtask

    // called at a negedge with inputs already set; returns at the next negedge
    task automatic cycle();
        #1;
        check_all();
        @(posedge Clk);
        model_step();
        @(negedge Clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    logic [31:0] words [3];
    int          ack_pct;

    initial begin
        words[0] = 32'h03B01001;
        words[1] = 32'h03B0A003;
        words[2] = 32'h02912003;
        model_reset();

        // reset held for 5 cycles
        @(negedge Clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("rst_instr", Instruction, NOP);
            chk("rst_req", MemReq, 1'b0);
            chk("rst_addr", MemAddr, 32'h0);
            cycle();
        end
        Clr = 1'b0;
        #1;
        chk("idle_req", MemReq, 1'b0);
        cycle();
        chk("first_req", MemReq, 1'b1);
        chk("first_addr", MemAddr, 32'h0);
        chk("wrap_addr0", w_addr, 32'hFFFFFFFC);
        chk("wrap_req0", w_req, 1'b1);

        // zero-wait stream
        for (int k = 0; k < 3; k++) begin
            chk("t2_addr", MemAddr, 32'(k * 4));
            MemAck  = 1'b1;
            MemData = words[k];
            cycle();
            MemAck = 1'b0;
            chk("t2_instr", Instruction, words[k]);
            chk("t2_ipc", InstrPC, 32'(k * 4));
            chk("t2_valid", InstrValid, 1'b1);
            if (k == 0) begin
                chk("wrap_ipc", w_ipc, 32'hFFFFFFFC);
                chk("wrap_next", w_addr, 32'h0);
            end
            cycle();
            chk("t2_gap", InstrValid, 1'b0);
        end
        chk("t2_addr_c", MemAddr, 32'hC);

        // stall while holding a word
        MemAck  = 1'b1;
        MemData = 32'h00923001;
        cycle();
        MemAck = 1'b0;
        Stall  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("t3_instr", Instruction, 32'h00923001);
            chk("t3_valid", InstrValid, 1'b1);
            chk("t3_req", MemReq, 1'b0);
            cycle();
        end
        Stall = 1'b0;
        cycle();
        chk("t3_next", MemAddr, 32'h10);
        chk("t3_req2", MemReq, 1'b1);

        // redirect over a late ack
        cycle();
        BranchTaken  = 1'b1;
        BranchTarget = 32'h103;
        MemAck       = 1'b1;
        MemData      = 32'hDEADBEEF;
        cycle();
        BranchTaken = 1'b0;
        MemAck      = 1'b0;
        chk("t4_req", MemReq, 1'b0);
        chk("t4_instr", Instruction, NOP);
        cycle();
        chk("t4_addr", MemAddr, 32'h100);
        chk("t4_req2", MemReq, 1'b1);

        // timeout
        run(TIMEOUT - 1);
        chk("t5_pre", FetchAbort, 1'b0);
        cycle();
        chk("t5_abort", FetchAbort, 1'b1);
        chk("t5_ipc", InstrPC, 32'h100);
        chk("t5_req", MemReq, 1'b0);
        MemAck = 1'b1;
        run(3);
        MemAck = 1'b0;
        chk("t5_sticky", FetchAbort, 1'b1);
        BranchTaken  = 1'b1;
        BranchTarget = 32'h0C;
        cycle();
        BranchTaken = 1'b0;
        chk("t5_clear", FetchAbort, 1'b0);
        cycle();
        chk("t5_addr", MemAddr, 32'hC);
        run(TIMEOUT + 2);
        chk("t5_abort2", FetchAbort, 1'b1);
        Clr = 1'b1;
        model_reset();
        #1;
        chk("t5_clr", FetchAbort, 1'b0);
        cycle();
        Clr = 1'b0;

        // randomized traffic
        ack_pct = 50;
        for (int n = 0; n < 3000; n++) begin
            if (n % 100 == 0) begin
                case ($urandom_range(0, 3))
                    0: ack_pct = 0;
                    1: ack_pct = 30;
                    2: ack_pct = 70;
                    default: ack_pct = 100;
                endcase
            end
            MemAck       = ($urandom_range(0, 99) < ack_pct);
            MemData      = $urandom;
            Stall        = ($urandom_range(0, 3) == 0);
            BranchTaken  = ($urandom_range(0, 39) == 0);
            BranchTarget = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFE : $urandom;
            Clr          = ($urandom_range(0, 299) == 0);
            if (Clr) model_reset();
            cycle();
        end
        Clr         = 1'b0;
        MemAck      = 1'b0;
        BranchTaken = 1'b0;
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
